// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_unit_pkg;
  localparam int          PC_WIDTH  = 15;
  localparam logic [15:0] ROM_WORDS = 16'h8000;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit counter that sticks at all-ones
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 16'h0000;
    end else if (en && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - zero-bubble instruction fetch from a 1-cycle-latency ROM
module fetch_unit #(
  parameter int                    PC_WIDTH   = 15,
  parameter logic [PC_WIDTH-1:0]   START_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                rom_ready,
  output logic [15:0]         rom_address,
  input  logic [15:0]         rom_instruction,
  input  logic                stall,
  input  logic                jump,
  input  logic [15:0]         jump_addr,
  output logic [15:0]         instr,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         fetch_count
);
  import fetch_unit_pkg::*;

  // Masking wraps pc+1 modulo 2^PC_WIDTH and keeps bit 15 clear.
  localparam logic [15:0] ADDR_MASK = 16'((32'd1 << PC_WIDTH) - 32'd1) & (ROM_WORDS - 16'd1);

  state_t      state;
  state_t      state_next;
  logic        advance;
  logic [15:0] addr_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else if (clken) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    advance     = 1'b0;
    addr_raw    = 16'(START_ADDR);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    unique case (state)
      LOAD:  if (rom_ready) state_next = PRIME;
      PRIME: state_next = RUN;
      RUN: begin
        instr_valid = 1'b1;
        instr       = rom_instruction;
        advance     = clken && !stall;
        if (advance && jump) begin
          addr_raw = jump_addr;
        end else if (advance) begin
          addr_raw = 16'(pc) + 16'd1;
        end else begin
          addr_raw = 16'(pc);
        end
        if (!rom_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  assign rom_address = addr_raw & ADDR_MASK;

  // pc tracks whatever address went to the ROM, so instr lines up with pc next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= START_ADDR;
    end else if (clken) begin
      if (state == PRIME) begin
        pc <= START_ADDR;
      end else if (state == RUN) begin
        pc <= rom_address[PC_WIDTH-1:0];
      end
    end
  end

  sat_counter16 u_count (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .count (fetch_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural fetch model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, clken, rom_ready, stall, jump;
  logic [15:0] jump_addr, rom_address, rom_instruction, instr, fetch_count;
  logic        instr_valid;
  logic [14:0] pc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  localparam logic [14:0] START = 15'h0000;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .clken           (clken),
    .rom_ready       (rom_ready),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .stall           (stall),
    .jump            (jump),
    .jump_addr       (jump_addr),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .fetch_count     (fetch_count)
  );

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  always @(posedge clk) rom_instruction <= word(rom_address);

  // warm: 0 = waiting for rom_ready, 1 = one more enabled cycle before words flow
  typedef struct packed {
    logic        valid;
    logic        warm;
    logic [14:0] pc;
    logic [15:0] cnt;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t cur);
    model_t n;
    n = cur;
    if (reset) begin
      n.valid = 1'b0; n.warm = 1'b0; n.pc = START; n.cnt = 16'd0;
    end else if (clken) begin
      if (cur.valid) begin
        if (!stall) begin
          n.cnt = (cur.cnt == 16'hFFFF) ? cur.cnt : cur.cnt + 16'd1;
          n.pc  = jump ? jump_addr[14:0] : cur.pc + 15'd1;
        end
        if (!rom_ready) begin
          n.valid = 1'b0; n.warm = 1'b0;
        end
      end else if (!cur.warm) begin
        if (rom_ready) n.warm = 1'b1;
      end else begin
        n.valid = 1'b1; n.warm = 1'b0; n.pc = START;
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] exp_addr(input model_t cur);
    if (!cur.valid) return {1'b0, START};
    if (clken && !stall) return jump ? {1'b0, jump_addr[14:0]} : {1'b0, cur.pc + 15'd1};
    return {1'b0, cur.pc};
  endfunction

  always @(posedge clk) m <= step(m);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("instr_valid", 32'(instr_valid), 32'(m.valid));
      check("instr", 32'(instr), m.valid ? 32'(word({1'b0, m.pc})) : 32'd0);
      if (m.valid) check("pc", 32'(pc), 32'(m.pc));
      check("fetch_count", 32'(fetch_count), 32'(m.cnt));
      check("rom_address", 32'(rom_address), 32'(exp_addr(m)));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; rom_ready = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = 16'h0000;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_addr", 32'(rom_address), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);

    tick(100);
    check("load_valid", 32'(instr_valid), 32'd0);
    rom_ready = 1'b1;
    tick();
    check("prime_valid", 32'(instr_valid), 32'd0);
    tick();
    check("run_valid", 32'(instr_valid), 32'd1);
    check("run_pc0", 32'(pc), 32'd0);
    check("run_instr0", 32'(instr), 32'hA5A5);

    tick(5);
    check("seq_pc5", 32'(pc), 32'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(pc), 32'd5);
      check("stall_instr", 32'(instr), 32'hA5A0);
      check("stall_count", 32'(fetch_count), 32'd5);
    end
    stall = 1'b0;
    tick();
    check("unstall_pc", 32'(pc), 32'd6);
    tick(4);
    check("seq_pc10", 32'(pc), 32'd10);
    check("seq_count10", 32'(fetch_count), 32'd10);

    jump = 1'b1; jump_addr = 16'h0007;
    tick();
    check("jump_pc7", 32'(pc), 32'd7);
    jump_addr = 16'h1234;
    tick();
    check("jump_pc", 32'(pc), 32'h1234);
    check("jump_instr", 32'(instr), 32'hB791);
    check("jump_valid", 32'(instr_valid), 32'd1);
    stall = 1'b1; jump_addr = 16'h0100;
    tick();
    check("jump_stall_pc", 32'(pc), 32'h1234);
    stall = 1'b0; jump_addr = 16'h7FFF;
    tick();
    check("jump_top_pc", 32'(pc), 32'h7FFF);
    jump = 1'b0;
    tick();
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_instr", 32'(instr), 32'hA5A5);
    check("wrap_count", 32'(fetch_count), 32'd14);

    clken = 1'b0; jump = 1'b1; jump_addr = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_pc", 32'(pc), 32'd0);
      check("frz_count", 32'(fetch_count), 32'd14);
      check("frz_valid", 32'(instr_valid), 32'd1);
    end
    clken = 1'b1; jump = 1'b0;
    tick();
    check("thaw_pc", 32'(pc), 32'd1);

    rom_ready = 1'b0;
    tick();
    check("drop_valid", 32'(instr_valid), 32'd0);
    rom_ready = 1'b1;
    tick(2);
    check("reload_valid", 32'(instr_valid), 32'd1);
    check("reload_pc", 32'(pc), 32'd0);

    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_count", 32'(fetch_count), 32'd0);
    tick();
    check("mid_rst_prime", 32'(instr_valid), 32'd0);
    tick();
    check("mid_rst_run", 32'(instr_valid), 32'd1);
    check("mid_rst_pc", 32'(pc), 32'd0);

    for (int i = 0; i < 400; i++) begin
      clken     = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      jump      = ($urandom_range(0, 4) == 0);
      jump_addr = 16'($urandom);
      rom_ready = ($urandom_range(0, 30) != 0);
      reset     = ($urandom_range(0, 80) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter START_ADDR, default 15'h0000, first instruction address fetched after ROM ready or reset.
REQ-002 Parameter PC_WIDTH, default 15, width of the program counter; only 32Ki words are loaded into instruction memory.
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clken  in  1  clock enable; state, pc and counter update only when high.
REQ-006 rom_ready  in  1  instruction memory finished loading from flash.
REQ-007 rom_address  out  16  word address to the instruction memory; bit 15 is always 0.
REQ-008 rom_instruction  in  16  memory data for the address presented on the previous clk edge (1-cycle latency).
REQ-009 stall  in  1  consumer cannot accept instr this cycle.
REQ-010 jump  in  1  redirect request, sampled only in an advance cycle.
REQ-011 jump_addr  in  16  redirect target; bits [14:0] are used.
REQ-012 instr  out  16  current instruction; 16'h0000 when instr_valid is low.
REQ-013 instr_valid  out  1  instr and pc are valid.
REQ-014 pc  out  15  address of instr.
REQ-015 fetch_count  out  16  count of consumed instructions, saturating.

Function
REQ-016 States: LOAD, PRIME, RUN; the state register is updated only when clken is high (reset excepted).
REQ-017 LOAD: rom_address=START_ADDR; when rom_ready is high, go to PRIME.
REQ-018 PRIME: rom_address=START_ADDR; pc<=START_ADDR; go to RUN.
REQ-019 RUN: instr_valid=1 and instr=rom_instruction, both combinational from the state.
REQ-020 Advance cycle: clken & RUN & !stall; this is the only cycle in which instr counts as consumed.
REQ-021 rom_address in RUN, by priority: advance&jump -> jump_addr[14:0]; advance -> pc+1; otherwise pc.
REQ-022 In any clken cycle in RUN, pc <= the rom_address driven in that cycle, so instr always matches pc one cycle later.
REQ-023 Stall or clken low in RUN: pc and rom_address hold; the same word is re-read; instr and pc remain stable.
REQ-024 Jump has zero bubble: the target instruction is valid in the next cycle; jump is ignored while stalled or while clken is low.
REQ-025 pc+1 wraps modulo 2^PC_WIDTH: 15'h7FFF -> 15'h0000, with no bubble.
REQ-026 rom_ready low while in RUN: go to LOAD; instr_valid drops in the next cycle.
REQ-027 fetch_count increments on every advance cycle and saturates at 16'hFFFF.
REQ-028 The rom_address path is combinational from stall and jump; every other output is a register or a decode of the state register.

Reset
REQ-029 reset overrides clken: state<=LOAD, pc<=START_ADDR, fetch_count<=0.
REQ-030 In the cycle after reset: instr_valid=0, instr=16'h0000, rom_address=START_ADDR.
REQ-031 Reset mid-RUN discards the in-flight fetch; if rom_ready is still high, instr_valid rises 2 clken cycles later.

Structure
REQ-032 Shared package contents: the state enum (LOAD, PRIME, RUN), PC_WIDTH, and the constant ROM_WORDS=16'h8000.
REQ-033 Sub-module: one, sat_counter16 (16-bit saturating counter with enable); everything else is inline.

Verification
REQ-034 rom_ready held low 100 cycles, then raised -> instr_valid=0 throughout LOAD; instr_valid=1 with pc=0 exactly 2 cycles after rom_ready rises.
REQ-035 Memory model word[n]=n^16'hA5A5, no stall -> each cycle pc increments by 1 and instr=pc^16'hA5A5; after 10 cycles fetch_count=10.
REQ-036 stall high 3 cycles at pc=5 -> pc=5 and instr=word[5] held for all 3 cycles; pc=6 in the cycle after stall falls; fetch_count unchanged during the stall.
REQ-037 jump=1 with jump_addr=16'h1234 at pc=7, no stall -> next cycle pc=15'h1234 and instr=word[0x1234], instr_valid never drops; jump with stall=1 -> ignored, pc unchanged.
REQ-038 pc=15'h7FFF advancing -> next pc=0 and instr=word[0]; clken held low 4 cycles -> all outputs frozen.
REQ-039 reset pulsed in RUN with rom_ready high -> 1 cycle in LOAD, then PRIME, then RUN at START_ADDR; fetch_count=0.
